data_mem_arbiter: RTL

//  Shares the single data_mem port between two requesters:
//  - m0: CPU load/store unit, priority port.
//  - m1: DMA / debug loader.

---
 rtl/data_mem_pkg.sv | 40 ++++
 rtl/data_mem_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and helpers for the data_mem arbiter
//
// Contents:
//   memctl_e      funct3 load/store width codes seen on the data_mem port
//   arb_state_e   arbiter ownership states
//   MEMCTL_IDLE   memcontrol value driven when nobody is granted
//   is_misaligned access legality check used when ARB_ALIGN_CHECK_EN is defined

package data_mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } memctl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic [2:0] MEMCTL_IDLE = LW;

  // Stores share the load codes (000/001/010), so one check covers both.
  // Codes with no defined width are treated as illegal.
  function automatic logic is_misaligned(input logic [1:0] addr, input logic [2:0] memctl);
    logic bad;
    case (memctl)
      LH, LHU:                bad = addr[0];
      LW:                     bad = (addr != 2'b00);
      3'b011, 3'b110, 3'b111: bad = 1'b1;
      default:                bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port arbiter in front of the single data_mem port
//
// m0 (CPU LSU) has priority; m1 (DMA/debug loader) is forced ahead once it has
// been refused MAX_WAIT cycles in a row. A grant with lock=1 keeps ownership for
// the next beat. Grant is combinational; load data returns one cycle later.
//
// Optional feature: define ARB_ALIGN_CHECK_EN to reject misaligned / illegal
// accesses (still granted, no write, rvalid+err the next cycle).
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   mN_req/lock/we/addr/wdata/memctl   requester N inputs (N=0,1)
//   mN_gnt                         request accepted this cycle
//   mN_rvalid/rdata/err            response, one cycle after a granted load
//   mem_a/we/writedata/memcontrol  to data_mem
//   mem_readdata                   from data_mem (combinational read)

module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_WAIT      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     m0_req,
  input  logic                     m0_lock,
  input  logic                     m0_we,
  input  logic [ADDRESS_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0]    m0_wdata,
  input  logic [2:0]               m0_memctl,
  output logic                     m0_gnt,
  output logic                     m0_rvalid,
  output logic [DATA_WIDTH-1:0]    m0_rdata,
  output logic                     m0_err,

  input  logic                     m1_req,
  input  logic                     m1_lock,
  input  logic                     m1_we,
  input  logic [ADDRESS_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0]    m1_wdata,
  input  logic [2:0]               m1_memctl,
  output logic                     m1_gnt,
  output logic                     m1_rvalid,
  output logic [DATA_WIDTH-1:0]    m1_rdata,
  output logic                     m1_err,

  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_writedata,
  output logic [2:0]               mem_memcontrol,
  input  logic [DATA_WIDTH-1:0]    mem_readdata
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  arb_state_e     state_q, state_d;
  logic [WCW-1:0] wait_cnt;
  logic           starved;
  logic           arb_free;
  logic           pick0, pick1;
  logic           reject0, reject1;

  assign starved = (wait_cnt == WCW'(MAX_WAIT));

`ifdef ARB_ALIGN_CHECK_EN
  assign reject0 = is_misaligned(m0_addr[1:0], m0_memctl);
  assign reject1 = is_misaligned(m1_addr[1:0], m1_memctl);
`else
  assign reject0 = 1'b0;
  assign reject1 = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Ownership FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // An owner that drops req gives the port back in that same cycle, so the
  // cycle is arbitrated exactly as if we were already in IDLE.
  always_comb begin
    arb_free = 1'b0;
    pick0    = 1'b0;
    pick1    = 1'b0;
    case (state_q)
      OWN0: begin
        arb_free = !m0_req;
        pick0    = m0_req;
      end
      OWN1: begin
        arb_free = !m1_req;
        pick1    = m1_req;
      end
      default: arb_free = 1'b1;
    endcase

    if (arb_free) begin
      if (m1_req && starved) pick1 = 1'b1;
      else if (m0_req)       pick0 = 1'b1;
      else if (m1_req)       pick1 = 1'b1;
    end

    if (pick0 && m0_lock)      state_d = OWN0;
    else if (pick1 && m1_lock) state_d = OWN1;
    else                       state_d = IDLE;
  end

  // Grants are masked while reset is asserted so no write can slip through.
  assign m0_gnt = pick0 & rst_n;
  assign m1_gnt = pick1 & rst_n;

  // ---------------------------------------------------------------------------
  // m1 anti-starvation counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!m1_req || m1_gnt) begin
      wait_cnt <= '0;
    end else if (!starved) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-side mux
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_a          = '0;
    mem_we         = 1'b0;
    mem_writedata  = '0;
    mem_memcontrol = MEMCTL_IDLE;
    if (m0_gnt) begin
      mem_a          = m0_addr;
      mem_we         = m0_we & ~reject0;
      mem_writedata  = m0_wdata;
      mem_memcontrol = m0_memctl;
    end else if (m1_gnt) begin
      mem_a          = m1_addr;
      mem_we         = m1_we & ~reject1;
      mem_writedata  = m1_wdata;
      mem_memcontrol = m1_memctl;
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers (rdata holds until the port's next response)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
    end else if (m0_gnt && reject0) begin
      m0_rvalid <= 1'b1;
      m0_rdata  <= '0;
    end else if (m0_gnt && !m0_we) begin
      m0_rvalid <= 1'b1;
      m0_rdata  <= mem_readdata;
    end else begin
      m0_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
    end else if (m1_gnt && reject1) begin
      m1_rvalid <= 1'b1;
      m1_rdata  <= '0;
    end else if (m1_gnt && !m1_we) begin
      m1_rvalid <= 1'b1;
      m1_rdata  <= mem_readdata;
    end else begin
      m1_rvalid <= 1'b0;
    end
  end

`ifdef ARB_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_err <= 1'b0;
      m1_err <= 1'b0;
    end else begin
      m0_err <= m0_gnt & reject0;
      m1_err <= m1_gnt & reject1;
    end
  end
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

endmodule
